// File: rtl/sram_rd_sequencer.sv
// sram_rd_sequencer
// Reads a burst of consecutive words from a single-port synchronous SRAM
// and streams them out over a valid/ready interface. The SRAM return path
// is captured into a 2-entry skid FIFO. A credit check keeps the reads in
// flight plus the buffered words within the FIFO depth.
//
// Optional feature: define SRAM_RD_SEQ_STALL_CNT_EN to add the 16-bit
// stall_cnt output. It counts cycles with out_valid=1 and out_ready=0.
module sram_rd_sequencer #(
  parameter int bw = 32,
  parameter int aw = 7,
  parameter int lw = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [aw-1:0] base_addr,
  input  logic [lw-1:0] len,
  output logic          busy,
  output logic          done,
  output logic          sram_cen,
  output logic          sram_wen,
  output logic [aw-1:0] sram_a,
  input  logic [bw-1:0] sram_q,
  output logic [bw-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
`ifdef SRAM_RD_SEQ_STALL_CNT_EN
  ,
  output logic [15:0]   stall_cnt
`endif
);

  // Longest burst supported; larger requests are clipped to this.
  localparam logic [lw-1:0] max_len = lw'(128);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;

  logic [aw-1:0]   addr_r;        // next SRAM address to read
  logic [lw-1:0]   issue_left_r;  // reads still to be issued
  logic [lw-1:0]   out_left_r;    // words still to be handed downstream
  logic            setup_r;       // first READ cycle: address just latched
  logic            q_vld_r;       // sram_q carries a requested word this cycle

  logic [bw-1:0]   fifo0_r;
  logic [bw-1:0]   fifo1_r;
  logic            wr_ptr_r;
  logic            rd_ptr_r;
  logic [1:0]      fifo_cnt_r;

  logic [lw-1:0]   len_eff_s;
  logic            start_acc_s;
  logic            pop_s;
  logic [2:0]      occ_s;
  logic            issue_s;

  // Clip the requested length to the supported maximum.
  always_comb begin
    len_eff_s = len;
    if (len > max_len) begin
      len_eff_s = max_len;
    end else begin
      len_eff_s = len;
    end
  end

  assign start_acc_s = (state_r == ST_IDLE) && start;
  assign out_valid   = (fifo_cnt_r != 2'd0);
  assign pop_s       = out_valid && out_ready;

  // Read issue: buffered words plus the word on the SRAM return path must
  // leave a free FIFO slot; a word leaving this cycle frees its slot. The
  // first READ cycle is spent settling the freshly latched address, which
  // puts the first word on the output three cycles after the start edge.
  always_comb begin
    occ_s   = {1'b0, fifo_cnt_r} + {2'b00, q_vld_r} - {2'b00, pop_s};
    issue_s = 1'b0;
    if ((state_r == ST_READ) && !setup_r && (issue_left_r != {lw{1'b0}})
        && (occ_s < 3'd2)) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
  end

  // Next-state logic for the burst controller.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (len_eff_s == {lw{1'b0}}) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_READ;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_READ: begin
        if (issue_s && (issue_left_r == lw'(1))) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_READ;
        end
      end
      ST_DRAIN: begin
        if (pop_s && (out_left_r == lw'(1))) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Burst bookkeeping: address pointer and remaining issue/transfer counts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_r       <= {aw{1'b0}};
      issue_left_r <= {lw{1'b0}};
      out_left_r   <= {lw{1'b0}};
      setup_r      <= 1'b0;
    end else if (start_acc_s) begin
      addr_r       <= base_addr;
      issue_left_r <= len_eff_s;
      out_left_r   <= len_eff_s;
      setup_r      <= 1'b1;
    end else begin
      setup_r <= 1'b0;
      if (issue_s) begin
        addr_r       <= addr_r + aw'(1);
        issue_left_r <= issue_left_r - lw'(1);
      end
      if (pop_s) begin
        out_left_r <= out_left_r - lw'(1);
      end
    end
  end

  // Track which cycles carry a requested word on sram_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_vld_r <= 1'b0;
    end else begin
      q_vld_r <= issue_s;
    end
  end

  // Two-entry skid FIFO holding returned words until accepted downstream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo0_r    <= {bw{1'b0}};
      fifo1_r    <= {bw{1'b0}};
      wr_ptr_r   <= 1'b0;
      rd_ptr_r   <= 1'b0;
      fifo_cnt_r <= 2'd0;
    end else begin
      if (q_vld_r) begin
        if (wr_ptr_r) begin
          fifo1_r <= sram_q;
        end else begin
          fifo0_r <= sram_q;
        end
        wr_ptr_r <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      fifo_cnt_r <= fifo_cnt_r + {1'b0, q_vld_r} - {1'b0, pop_s};
    end
  end

  assign out_data = rd_ptr_r ? fifo1_r : fifo0_r;
  assign busy     = (state_r != ST_IDLE);
  assign done     = (state_r == ST_DONE);
  assign sram_cen = ~issue_s;
  assign sram_wen = 1'b1;
  assign sram_a   = addr_r;

`ifdef SRAM_RD_SEQ_STALL_CNT_EN
  logic [15:0] stall_cnt_r;

  // Saturating count of back-pressured cycles for the current burst.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_r <= 16'd0;
    end else if (start_acc_s) begin
      stall_cnt_r <= 16'd0;
    end else if (out_valid && !out_ready && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
`endif

endmodule
